mul8_seq: RTL



---
 rtl/mul8_pkg.sv | 21 ++
 rtl/add8b.sv | 11 +
 rtl/mul8_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mul8_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier.
package mul8_pkg;

  localparam int MUL_STEPS = 8;
  localparam int MUL_W     = 8;

  // Counter value on the final shift-and-add step.
  localparam logic [2:0] LAST_STEP = 3'(MUL_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // True when the step counter sits on the final step.
  function automatic logic is_last_step(input logic [2:0] cnt);
    return (cnt == LAST_STEP);
  endfunction

endpackage

// File: rtl/add8b.sv
// Combinational 8-bit unsigned adder with carry out.
module add8b (
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] s,
  output logic       c_out
);

  assign {c_out, s} = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/mul8_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier with start/busy/done handshake.
// One add8b is reused for all eight steps; the 17-bit {carry, sum, q} is
// shifted right by one each step so the product assembles in {acc, q}.
module mul8_seq
  import mul8_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MUL_W-1:0]   a,
  input  logic [MUL_W-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*MUL_W-1:0] p
);

  mul_state_t         state_r;
  mul_state_t         state_next_s;
  logic [MUL_W-1:0]   m_r;
  logic [MUL_W-1:0]   acc_r;
  logic [MUL_W-1:0]   q_r;
  logic [2:0]         cnt_r;
  logic [2*MUL_W-1:0] p_r;
  logic               busy_r;
  logic               done_r;

  logic [MUL_W-1:0]   sum_s;
  logic               c_out_s;
  logic [MUL_W-1:0]   step_acc_s;
  logic [MUL_W-1:0]   step_q_s;
  logic               load_s;
  logic               step_s;
  logic               finish_s;

  add8b u_add8b (
    .x     (acc_r),
    .y     (m_r),
    .s     (sum_s),
    .c_out (c_out_s)
  );

  // Next {acc, q} for one step: add multiplicand when q[0] is set, then shift right.
  always_comb begin
    step_acc_s = {1'b0, acc_r[MUL_W-1:1]};
    step_q_s   = {acc_r[0], q_r[MUL_W-1:1]};
    if (q_r[0]) begin
      step_acc_s = {c_out_s, sum_s[MUL_W-1:1]};
      step_q_s   = {sum_s[0], q_r[MUL_W-1:1]};
    end else begin
      step_acc_s = {1'b0, acc_r[MUL_W-1:1]};
      step_q_s   = {acc_r[0], q_r[MUL_W-1:1]};
    end
  end

  // Controller next-state and datapath strobes.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
          load_s       = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (is_last_step(cnt_r)) begin
          finish_s     = 1'b1;
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register with registered busy/done decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == RUN) || (state_next_s == DONE);
      done_r  <= (state_next_s == DONE);
    end
  end

  // Operand load, shift-and-add steps, and product capture on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_r   <= {MUL_W{1'b0}};
      acc_r <= {MUL_W{1'b0}};
      q_r   <= {MUL_W{1'b0}};
      cnt_r <= 3'd0;
      p_r   <= {(2*MUL_W){1'b0}};
    end else if (load_s) begin
      m_r   <= a;
      q_r   <= b;
      acc_r <= {MUL_W{1'b0}};
      cnt_r <= 3'd0;
    end else if (step_s) begin
      acc_r <= step_acc_s;
      q_r   <= step_q_s;
      cnt_r <= cnt_r + 3'd1;
      if (finish_s) begin
        p_r <= {step_acc_s, step_q_s};
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign p    = p_r;

endmodule
